// File: rtl/regfile_storage.sv
// Register file storage: 31 writable 32-bit registers with r0 hardwired to zero.
// Has one synchronous write port and two combinational read ports. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_storage (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_writeReg,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);

  logic [31:0] regs [1:31];
  logic [31:0] writeSel;
  logic [31:0] selA;
  logic [31:0] selB;
  logic [31:0] storedA;
  logic [31:0] storedB;

  // One-hot write enable; bit 0 is forced low so r0 can never be written.
  always_comb begin
    writeSel = '0;
    if (ctrl_writeEnable) begin
      writeSel = 32'h1 << ctrl_writeReg;
    end
    writeSel[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (writeSel[i]) begin
          regs[i] <= data_writeReg;
        end
      end
    end
  end

  // AND-OR one-hot read muxes; index 0 selects nothing, so r0 reads zero.
  always_comb begin
    selA    = 32'h1 << ctrl_readRegA;
    selB    = 32'h1 << ctrl_readRegB;
    storedA = '0;
    storedB = '0;
    for (int i = 1; i < 32; i++) begin
      storedA = storedA | (regs[i] & {32{selA[i]}});
      storedB = storedB | (regs[i] & {32{selB[i]}});
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic bypassA;
  logic bypassB;

  // writeSel already excludes r0; reset gating keeps outputs at zero during reset.
  always_comb begin
    bypassA = !ctrl_reset && writeSel[ctrl_readRegA];
    bypassB = !ctrl_reset && writeSel[ctrl_readRegB];
    data_readRegA = bypassA ? data_writeReg : storedA;
    data_readRegB = bypassB ? data_writeReg : storedB;
  end
`else
  always_comb begin
    data_readRegA = storedA;
    data_readRegB = storedB;
  end
`endif

endmodule

// File: tb/tb_regfile_storage.sv
// Scoreboard bench for regfile_storage: a stimulus process queues expected reads from an array model.
// A monitor pops each entry and compares it with the DUT outputs.
module tb_regfile_storage;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] expA;
    logic [31:0] expB;
  } expect_t;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  logic [31:0] model [32];
  expect_t     sbQueue [$];
  event        sampleEvt;
  int          total = 0;
  int          bad = 0;

  regfile_storage dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  always #5 clock = ~clock;

  // Reference read: zero in reset, the write data when bypassing, otherwise the stored value.
  function automatic logic [31:0] expRead(input logic [4:0] idx);
    if (ctrl_reset) return 32'h0;
    if (BYPASS && ctrl_writeEnable && ctrl_writeReg != 5'd0 && idx == ctrl_writeReg)
      return data_writeReg;
    if (idx == 5'd0) return 32'h0;
    return model[idx];
  endfunction

  task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [4:0] ra,
                               input logic [4:0] rb, input logic [31:0] data);
    ctrl_writeEnable = we;
    ctrl_writeReg    = wr;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    data_writeReg    = data;
  endtask

  task automatic checkOutput(input string name);
    expect_t e;
    #1;
    e.name = name;
    e.expA = expRead(ctrl_readRegA);
    e.expB = expRead(ctrl_readRegB);
    sbQueue.push_back(e);
    -> sampleEvt;
    #1;
  endtask

  // Advance one clock, committing the write into the model the way the architecture defines it.
  task automatic clockEdge();
    @(posedge clock);
    if (!ctrl_reset && ctrl_writeEnable && ctrl_writeReg != 5'd0)
      model[ctrl_writeReg] = data_writeReg;
    @(negedge clock);
  endtask

  task automatic assertReset();
    ctrl_reset = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(sampleEvt);
      while (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        total++;
        if (data_readRegA !== e.expA || data_readRegB !== e.expB) begin
          bad++;
          $display("[TB] FAIL %s: A=%h B=%h expected A=%h B=%h",
                   e.name, data_readRegA, data_readRegB, e.expA, e.expB);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    assertReset();
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom), $urandom);
      checkOutput("reset_state");
      clockEdge();
    end
    ctrl_reset = 1'b0;

    applyStimulus(1'b1, 5'd5, 5'd5, 5'd31, 32'hDEADBEEF);
    clockEdge();
    applyStimulus(1'b1, 5'd31, 5'd5, 5'd31, 32'h12345678);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 5'd5, 5'd31, 32'h0);
    checkOutput("basic_r5_r31");
    applyStimulus(1'b0, 5'd0, 5'd6, 5'd30, 32'h0);
    checkOutput("basic_others_zero");

    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    checkOutput("r0_write_pre");
    clockEdge();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    checkOutput("r0_protect");

    applyStimulus(1'b1, 5'd7, 5'd0, 5'd0, 32'h1);
    clockEdge();
    applyStimulus(1'b1, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5);
    checkOutput("r7_same_cycle_before");
    clockEdge();
    applyStimulus(1'b0, 5'd7, 5'd7, 5'd7, 32'h0);
    checkOutput("r7_after_edge");

    applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 32'h3333);
    clockEdge();
    applyStimulus(1'b0, 5'd3, 5'd3, 5'd3, 32'hCAFEF00D);
    checkOutput("we_low_before");
    clockEdge();
    checkOutput("we_low_r3_unchanged");

    // Random traffic, checked both before and after each edge.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      if (n % 4 == 0) ctrl_readRegA = ctrl_writeReg;
      checkOutput("random_pre");
      clockEdge();
      checkOutput("random_post");
    end

    applyStimulus(1'b1, 5'd9, 5'd9, 5'd9, 32'h55);
    clockEdge();
    applyStimulus(1'b1, 5'd9, 5'd9, 5'd1, 32'h77);
    checkOutput("r9_before_reset");
    assertReset();
    checkOutput("r9_reset_midcycle");
    clockEdge();
    checkOutput("r9_write_lost");
    ctrl_reset = 1'b0;
    applyStimulus(1'b1, 5'd9, 5'd9, 5'd9, 32'h66);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 5'd9, 5'd9, 32'h0);
    checkOutput("r9_after_reset");

    // Fill every register, then reset between edges and sweep all indices on both ports.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 5'd0, 5'd0, $urandom | 32'h1);
      clockEdge();
    end
    applyStimulus(1'b0, 5'd0, 5'd12, 5'd20, 32'h0);
    checkOutput("filled_before_reset");
    assertReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 5'(i), 5'(31 - i), 32'h0);
      checkOutput("reset_sweep");
    end
    ctrl_reset = 1'b0;
    @(negedge clock);

    for (int t = 0; t < 100 && sbQueue.size() > 0; t++) #1;
    if (sbQueue.size() > 0) begin
      bad++;
      total++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQueue.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
